// File: rtl/mic_pdm_rx.sv
// PDM microphone receiver: divides the audio clock for the mic, decimates the
// 1-bit stream with a 3rd-order CIC (R=64) and hands out 16-bit PCM via valid/ready.
module mic_pdm_rx #(
  parameter int DISCARD = 3
) (
  input  logic               clk_12m288,
  input  logic               reset,
  input  logic               en,
  output logic               mic_clk,
  output logic               mic_lrsel,
  input  logic               mic_data,
  output logic signed [15:0] pcm_data,
  output logic               pcm_valid,
  input  logic               pcm_ready,
  output logic               overrun
);

  localparam int DW = $clog2(DISCARD + 2);
  localparam logic [DW-1:0] DISC_MAX = DW'(DISCARD);

  logic [1:0]  phase_reg;
  logic        sync1_reg, sync2_reg;
  logic [18:0] int1_reg, int2_reg, int3_reg;
  logic [18:0] int3_d_reg, comb1_reg, comb1_d_reg, comb2_reg, comb2_d_reg;
  logic [5:0]  dec_cnt_reg;
  logic [2:0]  pipe_reg;
  logic [DW-1:0] disc_cnt_reg;
  logic        pcm_valid_reg, overrun_reg;
  logic signed [15:0] pcm_data_reg;

  logic        sample_tick, dec_tick, load;
  logic [18:0] comb3;
  logic signed [19:0] diff_s, shr_s;
  logic signed [15:0] sat_s;

  assign sample_tick = en && (phase_reg == 2'd3);
  assign dec_tick    = sample_tick && (dec_cnt_reg == 6'd63);

  // Third comb stage is folded into the output load cycle.
  assign comb3  = comb2_reg - comb2_d_reg;
  assign diff_s = $signed({1'b0, comb3}) - 20'sd131072;
  assign shr_s  = diff_s >>> 2;

  always_comb begin
    if (shr_s > 20'sd32767)
      sat_s = 16'sh7FFF;
    else if (shr_s < -20'sd32768)
      sat_s = 16'sh8000;
    else
      sat_s = shr_s[15:0];
  end

  assign load = en && pipe_reg[2] && (disc_cnt_reg == DISC_MAX);

  always_ff @(posedge clk_12m288) begin
    if (reset) begin
      phase_reg     <= '0;
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      int1_reg      <= '0;
      int2_reg      <= '0;
      int3_reg      <= '0;
      int3_d_reg    <= '0;
      comb1_reg     <= '0;
      comb1_d_reg   <= '0;
      comb2_reg     <= '0;
      comb2_d_reg   <= '0;
      dec_cnt_reg   <= '0;
      pipe_reg      <= '0;
      disc_cnt_reg  <= '0;
      pcm_data_reg  <= '0;
      pcm_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync1_reg <= mic_data;
      sync2_reg <= sync1_reg;

      if (!en) begin
        phase_reg    <= '0;
        int1_reg     <= '0;
        int2_reg     <= '0;
        int3_reg     <= '0;
        int3_d_reg   <= '0;
        comb1_reg    <= '0;
        comb1_d_reg  <= '0;
        comb2_reg    <= '0;
        comb2_d_reg  <= '0;
        dec_cnt_reg  <= '0;
        pipe_reg     <= '0;
        disc_cnt_reg <= '0;
      end else begin
        phase_reg <= phase_reg + 2'd1;
        if (sample_tick) begin
          int1_reg    <= int1_reg + {18'd0, sync2_reg};
          int2_reg    <= int2_reg + int1_reg;
          int3_reg    <= int3_reg + int2_reg;
          dec_cnt_reg <= dec_cnt_reg + 6'd1;
        end
        pipe_reg <= {pipe_reg[1:0], dec_tick};
        if (pipe_reg[0]) begin
          comb1_reg  <= int3_reg - int3_d_reg;
          int3_d_reg <= int3_reg;
        end
        if (pipe_reg[1]) begin
          comb2_reg   <= comb1_reg - comb1_d_reg;
          comb1_d_reg <= comb1_reg;
        end
        if (pipe_reg[2]) begin
          comb2_d_reg <= comb2_reg;
          if (disc_cnt_reg < DISC_MAX)
            disc_cnt_reg <= disc_cnt_reg + 1'b1;
        end
      end

      // A load wins over a transfer; it only overruns if nobody took the old sample.
      overrun_reg <= 1'b0;
      if (load) begin
        pcm_data_reg  <= sat_s;
        pcm_valid_reg <= 1'b1;
        overrun_reg   <= pcm_valid_reg && !pcm_ready;
      end else if (pcm_valid_reg && pcm_ready) begin
        pcm_valid_reg <= 1'b0;
      end
    end
  end

  assign mic_clk   = phase_reg[1];
  assign mic_lrsel = 1'b0;
  assign pcm_data  = pcm_data_reg;
  assign pcm_valid = pcm_valid_reg;
  assign overrun   = overrun_reg;

endmodule
